// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall controller for the 5-stage pipeline: per-stage enable/hold/bubble/flush
// controls, data-memory request sequencing, saturating perf counters and a sticky timeout flag.
module pipeline_hazard_ctrl #(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       ifid_rs1,
    input  logic [4:0]       ifid_rs2,
    input  logic             ifid_uses_rs2,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rd,
    input  logic             exmem_memread,
    input  logic             exmem_memwrite,
    input  logic             exmem_branch_taken,
    input  logic             dmem_ready,
    output logic             dmem_req,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             idex_hold,
    output logic             exmem_hold,
    output logic             memwb_bubble,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic             mem_timeout
);

    localparam int unsigned WAIT_W = 16;
    localparam logic [WAIT_W-1:0] WAIT_MAX = {WAIT_W{1'b1}};
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(WAIT_LIMIT);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic [CNT_W-1:0]  flush_q, flush_d;
    logic              timeout_q, timeout_d;

    logic memop;
    logic freeze;
    logic load_use_hit;
    logic branch_flush;
    logic lu_stall;

    // Event decode; reset masks every event so nothing is counted while it is held.
    assign memop        = exmem_memread | exmem_memwrite;
    assign freeze       = !reset && !dmem_ready && ((state_q == ST_MEM_WAIT) || memop);
    assign load_use_hit = idex_memread && (idex_rd != 5'd0) &&
                          ((idex_rd == ifid_rs1) || (ifid_uses_rs2 && (idex_rd == ifid_rs2)));
    assign branch_flush = !reset && !freeze && exmem_branch_taken;
    assign lu_stall     = !reset && !freeze && !exmem_branch_taken && load_use_hit;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (memop && !dmem_ready) begin
                    state_d = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (dmem_ready) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Output decode: memory wait > branch flush > load-use stall
    always_comb begin
        dmem_req     = 1'b0;
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        idex_bubble  = 1'b0;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_flush  = 1'b0;
        idex_hold    = 1'b0;
        exmem_hold   = 1'b0;
        memwb_bubble = 1'b0;
        if (reset) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            exmem_flush  = 1'b1;
            memwb_bubble = 1'b1;
        end else begin
            dmem_req = memop || (state_q == ST_MEM_WAIT);
            if (freeze) begin
                pc_write     = 1'b0;
                ifid_write   = 1'b0;
                idex_hold    = 1'b1;
                exmem_hold   = 1'b1;
                memwb_bubble = 1'b1;
            end else if (branch_flush) begin
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
            end else if (lu_stall) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end
        end
    end

    // Wait counter, timeout flag and performance counter next values
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        stall_d    = stall_q;
        flush_d    = flush_q;
        if (freeze) begin
            if (state_q == ST_RUN) begin
                wait_cnt_d = WAIT_W'(1);
            end else if (wait_cnt_q != WAIT_MAX) begin
                wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
        end else begin
            wait_cnt_d = '0;
        end
        timeout_d = timeout_q || (freeze && (wait_cnt_d >= WAIT_LIM));
        if ((freeze || lu_stall) && (stall_q != CNT_MAX)) begin
            stall_d = stall_q + CNT_W'(1);
        end
        if (branch_flush && (flush_q != CNT_MAX)) begin
            flush_d = flush_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= '0;
            stall_q    <= '0;
            flush_q    <= '0;
            timeout_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            stall_q    <= stall_d;
            flush_q    <= flush_d;
            timeout_q  <= timeout_d;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
    assign mem_timeout  = timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench for pipeline_hazard_ctrl with a narrow counter and short wait limit.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned CNT_W = 4;

    // Control vector order: {dmem_req, pc_write, ifid_write, idex_bubble,
    //  ifid_flush, idex_flush, exmem_flush, idex_hold, exmem_hold, memwb_bubble}
    localparam logic [9:0] C_DEF = 10'b0_11_0_000_00_0;
    localparam logic [9:0] C_RST = 10'b0_00_0_111_00_1;
    localparam logic [9:0] C_LU  = 10'b0_00_1_000_00_0;
    localparam logic [9:0] C_BR  = 10'b0_11_0_111_00_0;
    localparam logic [9:0] C_FRZ = 10'b1_00_0_000_11_1;
    localparam logic [9:0] C_MOK = 10'b1_11_0_000_00_0;
    localparam logic [9:0] C_MBR = 10'b1_11_0_111_00_0;

    typedef struct packed {
        logic [9:0]       ctl;
        logic [CNT_W-1:0] stall;
        logic [CNT_W-1:0] flush;
        logic             tmo;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       ifid_rs1, ifid_rs2, idex_rd;
    logic             ifid_uses_rs2, idex_memread;
    logic             exmem_memread, exmem_memwrite, exmem_branch_taken, dmem_ready;
    logic             dmem_req, pc_write, ifid_write, idex_bubble;
    logic             ifid_flush, idex_flush, exmem_flush, idex_hold, exmem_hold, memwb_bubble;
    logic [CNT_W-1:0] stall_cycles, flush_count;
    logic             mem_timeout;

    exp_t sb_q[$];
    int   n_total  = 0;
    int   n_passed = 0;

    pipeline_hazard_ctrl #(.CNT_W(CNT_W), .WAIT_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_uses_rs2(ifid_uses_rs2),
        .idex_memread(idex_memread), .idex_rd(idex_rd),
        .exmem_memread(exmem_memread), .exmem_memwrite(exmem_memwrite),
        .exmem_branch_taken(exmem_branch_taken), .dmem_ready(dmem_ready),
        .dmem_req(dmem_req), .pc_write(pc_write), .ifid_write(ifid_write),
        .idex_bubble(idex_bubble), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .idex_hold(idex_hold), .exmem_hold(exmem_hold),
        .memwb_bubble(memwb_bubble), .stall_cycles(stall_cycles),
        .flush_count(flush_count), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) begin
            n_passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One cycle: drive inputs after the edge, queue the expectation, compare at the falling edge.
    task automatic cyc(input string tag, input logic rst,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic use2,
                       input logic ldx, input logic [4:0] rd,
                       input logic mrd, input logic mwr, input logic br, input logic rdy,
                       input logic [9:0] ctl, input int st, input int fl, input logic tmo);
        exp_t e;
        logic [9:0] obs;
        @(posedge clk);
        #1;
        reset = rst; ifid_rs1 = rs1; ifid_rs2 = rs2; ifid_uses_rs2 = use2;
        idex_memread = ldx; idex_rd = rd; exmem_memread = mrd; exmem_memwrite = mwr;
        exmem_branch_taken = br; dmem_ready = rdy;
        e.ctl = ctl; e.stall = CNT_W'(st); e.flush = CNT_W'(fl); e.tmo = tmo;
        sb_q.push_back(e);
        @(negedge clk);
        e = sb_q.pop_front();
        obs = {dmem_req, pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush,
               exmem_flush, idex_hold, exmem_hold, memwb_bubble};
        chk({tag, ".ctl"}, 32'(obs), 32'(e.ctl));
        chk({tag, ".stall"}, 32'(stall_cycles), 32'(e.stall));
        chk({tag, ".flush"}, 32'(flush_count), 32'(e.flush));
        chk({tag, ".tmo"}, 32'(mem_timeout), 32'(e.tmo));
    endtask

    task automatic idle(input string tag, input int st, input int fl, input logic tmo);
        cyc(tag, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_DEF, st, fl, tmo);
    endtask

    initial begin
        reset = 1'b1; ifid_rs1 = '0; ifid_rs2 = '0; ifid_uses_rs2 = 1'b0;
        idex_memread = 1'b0; idex_rd = '0; exmem_memread = 1'b0; exmem_memwrite = 1'b0;
        exmem_branch_taken = 1'b0; dmem_ready = 1'b0;
        repeat (2) @(posedge clk);

        // Reset overrides every event
        cyc("rst_override", 1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, C_RST, 0, 0, 1'b0);
        idle("idle0", 0, 0, 1'b0);

        // Load-use hazards
        cyc("lu_rs1", 1'b0, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, C_LU, 0, 0, 1'b0);
        idle("lu_done", 1, 0, 1'b0);
        cyc("lu_rd0", 1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_DEF, 1, 0, 1'b0);
        cyc("rs2_unused", 1'b0, 5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, C_DEF, 1, 0, 1'b0);
        cyc("lu_rs2", 1'b0, 5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, C_LU, 1, 0, 1'b0);
        idle("idle1", 2, 0, 1'b0);

        // Branch wins over a simultaneous load-use match
        cyc("br_over_lu", 1'b0, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, C_BR, 2, 0, 1'b0);
        idle("br_done", 2, 1, 1'b0);

        // Memory: immediate hit, then three wait cycles (with a load-use match masked by the freeze)
        cyc("mem_hit", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, C_MOK, 2, 1, 1'b0);
        for (int i = 0; i < 3; i++)
            cyc("mem_frz", 1'b0, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, C_FRZ, 2 + i, 1, 1'b0);
        cyc("mem_rel", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, C_MOK, 5, 1, 1'b0);
        idle("run_idle", 5, 1, 1'b0);

        // Branch held during a freeze is acted on in the release cycle
        cyc("frz_br", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, C_FRZ, 5, 1, 1'b0);
        cyc("rel_br", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, C_MBR, 6, 1, 1'b0);
        idle("idle2", 6, 2, 1'b0);

        // Six wait cycles against a limit of four; flag is sticky past release
        for (int i = 0; i < 6; i++)
            cyc("tmo_frz", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, C_FRZ, 6 + i, 2, 1'(i >= 4));
        cyc("tmo_rel", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, C_MOK, 12, 2, 1'b1);
        idle("tmo_sticky", 12, 2, 1'b1);

        // Counter saturation
        for (int i = 0; i < 20; i++)
            cyc("stall_sat", 1'b0, 5'd9, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, C_LU,
                (12 + i > 15) ? 15 : 12 + i, 2, 1'b1);
        idle("stall_held", 15, 2, 1'b1);
        for (int i = 0; i < 17; i++)
            cyc("flush_sat", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, C_BR,
                15, (2 + i > 15) ? 15 : 2 + i, 1'b1);
        idle("flush_held", 15, 15, 1'b1);

        // Reset in the middle of a memory wait
        cyc("wait_pre_rst", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, C_FRZ, 15, 15, 1'b1);
        cyc("rst_in_wait", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, C_RST, 15, 15, 1'b1);
        idle("post_rst", 0, 0, 1'b0);
        cyc("frz_again", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, C_FRZ, 0, 0, 1'b0);
        cyc("rel_again", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, C_MOK, 1, 0, 1'b0);
        idle("final", 1, 0, 1'b0);

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and stall controller for the 5-stage 64-bit RISC-V core. It generates the per-stage write-enable, hold, bubble and flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It sequences the data-memory request/ready handshake, so that a slow memory freezes the pipe and the MEM/WB register receives a bubble. It also keeps saturating stall and flush counters and a sticky memory-timeout flag.

## Interface
Parameters:
- CNT_W, 32, width of stall/flush performance counters
- WAIT_LIMIT, 255, MEM_WAIT cycles after which mem_timeout sets (1..2^16-1)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- ifid_rs1, ifid_rs2  in  5  source registers of the instruction in ID
- ifid_uses_rs2  in  1  ID instruction reads rs2
- idex_memread  in  1  instruction in EX is a load
- idex_rd  in  5  destination of instruction in EX
- exmem_memread, exmem_memwrite  in  1  MEM-stage memory op
- exmem_branch_taken  in  1  branch resolved taken in MEM
- dmem_ready  in  1  data memory completes current access this cycle
- dmem_req  out  1  data memory request
- pc_write, ifid_write  out  1  update enables
- idex_bubble  out  1  load zeros/NOP controls into ID/EX
- ifid_flush, idex_flush, exmem_flush  out  1  clear stage register next edge
- idex_hold, exmem_hold  out  1  keep stage register contents
- memwb_bubble  out  1  MEM/WB captures Regwrite=0, Memtoreg=0
- stall_cycles, flush_count  out  CNT_W  performance counters
- mem_timeout  out  1  sticky: a memory wait reached WAIT_LIMIT

## Operation
- State: RUN, MEM_WAIT (registered). Wait counter of 16 bits.
- memop = exmem_memread | exmem_memwrite.
- Control outputs are combinational from state and inputs. Default with no event: pc_write=1, ifid_write=1, all other controls 0.
- Priority is memory wait > branch flush > load-use stall.
- Memory, RUN state:
  - dmem_req = memop.
  - memop & dmem_ready: access completes, no stall.
  - memop & !dmem_ready: freeze this cycle (pc_write=0, ifid_write=0, idex_hold=1, exmem_hold=1, memwb_bubble=1). Go to MEM_WAIT, wait counter=1.
- Memory, MEM_WAIT state:
  - dmem_req=1.
  - !dmem_ready: freeze as above, wait counter +1 (saturating).
  - dmem_ready: release; defaults apply, memwb_bubble=0. Go to RUN.
  - The wait counter reaching WAIT_LIMIT sets mem_timeout. The block keeps waiting; it does not abort.
- Branch (only when not frozen): exmem_branch_taken forces ifid_flush=1, idex_flush=1, exmem_flush=1, pc_write=1 (target mux external). A load-use stall is suppressed in that cycle.
- Load-use (only when not frozen and no branch): asserted when idex_memread, idex_rd!=0, and (idex_rd==ifid_rs1 or (ifid_uses_rs2 and idex_rd==ifid_rs2)). Response: pc_write=0, ifid_write=0, idex_bubble=1.
- A branch held in EX/MEM during a freeze is acted on in the release cycle. exmem_branch_taken stays stable because EX/MEM is held.
- Counters:
  - stall_cycles +1 per cycle with a freeze or load-use stall.
  - flush_count +1 per cycle with a branch flush.
  - Both saturate at 2^CNT_W-1.

## Timing
- While reset is high:
  - pc_write=0, ifid_write=0.
  - ifid_flush=idex_flush=exmem_flush=1, memwb_bubble=1.
  - dmem_req=0, holds=0, idex_bubble=0.
- First edge with reset high: state=RUN, wait counter=0, counters=0, mem_timeout=0.
- Reset asserted during MEM_WAIT returns the block to RUN at that edge and drops dmem_req immediately.
- Zero-latency control: outputs respond in the same cycle as inputs. State and counters update at the edge.
- A load-use stall lasts exactly 1 cycle. A branch flush lasts exactly 1 cycle.
- A memory access with ready low for N cycles freezes the pipe for N cycles. MEM/WB gets N bubbles.
- dmem_req must not drop in MEM_WAIT until the cycle dmem_ready=1.

## Test plan
- Load x5 in EX, ID reads rs1=5 -> exactly one cycle with pc_write=0, ifid_write=0, idex_bubble=1; stall_cycles=1. Same with rd=0 -> no stall.
- exmem_memread=1, dmem_ready low 3 cycles then high -> 3 freeze cycles with memwb_bubble=1 and dmem_req held high; release on 4th cycle; stall_cycles=3; state back to RUN.
- exmem_branch_taken=1 with a simultaneous load-use match -> ifid/idex/exmem_flush=1, idex_bubble=0, pc_write=1; flush_count=1.
- WAIT_LIMIT=4, dmem_ready low 6 cycles -> mem_timeout rises after 4th wait cycle and stays high after release, until reset.
- reset pulsed mid-MEM_WAIT -> next cycle dmem_req=0, state RUN, counters 0, mem_timeout 0.
- CNT_W=4, 20 consecutive stall cycles -> stall_cycles holds 15.
